// File: rtl/kp_pkg.sv
// Shared types for the scanned 4x4 keypad reader.
// Holds FSM/frame encodings and the frame classifier.
package kp_pkg;

  localparam int NUM_COL = 4;
  localparam int NUM_ROW = 4;
  localparam int KEY_W   = 4;
  localparam int NUM_KEY = NUM_COL * NUM_ROW;

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    DB_RELEASE
  } kp_state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_cls_t;

  typedef struct packed {
    frame_cls_t       cls;
    logic [KEY_W-1:0] key;
  } frame_t;

  function automatic frame_t classify(
    input logic [NUM_KEY-1:0] snap
  );
    frame_t f;
    int     n;
    n     = 0;
    f.key = '0;
    for (int i = NUM_KEY - 1; i >= 0; i--) begin
      if (snap[i]) begin
        n++;
        f.key = KEY_W'(i);
      end
    end
    if (n == 0)      f.cls = NONE;
    else if (n == 1) f.cls = SINGLE;
    else             f.cls = MULTI;
    return f;
  endfunction

endpackage

// File: rtl/kp_if.sv
// Keypad matrix and key-event bundle.
// master drives columns and events; slave drives rows.
interface kp_if;
  import kp_pkg::*;

  logic [NUM_COL-1:0] o_col;
  logic [NUM_ROW-1:0] i_row;
  logic [KEY_W-1:0]   o_key_code;
  logic               o_key_valid;
  logic               o_key_held;
  logic               o_key_release;

  modport master (
    output o_col,
    output o_key_code,
    output o_key_valid,
    output o_key_held,
    output o_key_release,
    input  i_row
  );

  modport slave (
    input  o_col,
    input  o_key_code,
    input  o_key_valid,
    input  o_key_held,
    input  o_key_release,
    output i_row
  );

endinterface

// File: rtl/kp_scan_tick.sv
// Column scanner: divider, column rotation, row sync and
// the per-frame pressed-key snapshot.
module kp_scan_tick
  import kp_pkg::*;
#(
  parameter int SCAN_DIV = 5000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_ROW-1:0] row,
  output logic [NUM_COL-1:0] col,
  output logic [NUM_KEY-1:0] snap,
  output logic               frame_end
);

  logic [31:0]        div;
  logic [1:0]         col_idx;
  logic [NUM_ROW-1:0] row_s1;
  logic [NUM_ROW-1:0] row_s2;
  logic [NUM_KEY-1:0] snap_q;
  logic               tc;

  assign tc        = div == 32'(SCAN_DIV - 1);
  assign frame_end = tc && (col_idx == 2'd3);

  // Merge the current column on tc so the frame end sees all 16 bits.
  always_comb begin
    snap = snap_q;
    if (tc) snap[{col_idx, 2'b00} +: NUM_ROW] = ~row_s2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div     <= '0;
      col_idx <= '0;
      col     <= 4'b1110;
      row_s1  <= '1;
      row_s2  <= '1;
      snap_q  <= '0;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
      if (tc) begin
        div     <= '0;
        col_idx <= col_idx + 2'd1;
        col     <= {col[NUM_COL-2:0], col[NUM_COL-1]};
        snap_q  <= snap;
      end else begin
        div <= div + 32'd1;
      end
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad reader: frame classifier and press/release
// debounce FSM on top of the column scanner.
module keypad_scan
  import kp_pkg::*;
#(
  parameter int SCAN_DIV        = 5000,
  parameter int DEBOUNCE_FRAMES = 20
) (
  input logic clk,
  input logic rst_n,
  kp_if.master kp
);

  localparam logic ONE_SHOT = DEBOUNCE_FRAMES == 1;

  logic [NUM_COL-1:0] col;
  logic [NUM_KEY-1:0] snap;
  logic               frame_end;

  kp_scan_tick #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (kp.i_row),
    .col      (col),
    .snap     (snap),
    .frame_end(frame_end)
  );

  kp_state_t        state_q, state_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
  logic             rel_q, rel_d;
  frame_t           fr;
  logic [8:0]       cnt_inc;
  logic             hit;

  assign fr      = classify(snap);
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;
  assign hit     = cnt_inc == 9'(DEBOUNCE_FRAMES);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    rel_d   = 1'b0;
    if (frame_end) begin
      unique case (state_q)
        IDLE: begin
          if (fr.cls == SINGLE) begin
            state_d = DB_PRESS;
            cand_d  = fr.key;
            cnt_d   = 8'd1;
            if (ONE_SHOT) begin
              state_d = PRESSED;
              code_d  = fr.key;
              valid_d = 1'b1;
              held_d  = 1'b1;
            end
          end
        end
        DB_PRESS: begin
          if (fr.cls == SINGLE && fr.key == cand_q) begin
            cnt_d = cnt_inc[7:0];
            if (hit) begin
              state_d = PRESSED;
              code_d  = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
            end
          end else if (fr.cls == SINGLE) begin
            cand_d = fr.key;
            cnt_d  = 8'd1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          if (fr.cls == NONE) begin
            state_d = DB_RELEASE;
            cnt_d   = 8'd1;
            if (ONE_SHOT) begin
              state_d = IDLE;
              rel_d   = 1'b1;
              held_d  = 1'b0;
            end
          end
        end
        DB_RELEASE: begin
          if (fr.cls == NONE) begin
            cnt_d = cnt_inc[7:0];
            if (hit) begin
              state_d = IDLE;
              rel_d   = 1'b1;
              held_d  = 1'b0;
            end
          end else begin
            state_d = PRESSED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      rel_q   <= rel_d;
    end
  end

  assign kp.o_col         = col;
  assign kp.o_key_code    = code_q;
  assign kp.o_key_valid   = valid_q;
  assign kp.o_key_held    = held_q;
  assign kp.o_key_release = rel_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a virtual key matrix driven per frame,
// checked cycle by cycle against a run-length debounce model.
module tb_keypad_scan;

  localparam int SD = 4;
  localparam int DF = 3;
  localparam int FR = 4 * SD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kp_if kp ();

  keypad_scan #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_FRAMES(DF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kp   (kp)
  );

  logic [15:0] keys = '0;
  int total = 0;
  int bad   = 0;

  // Virtual matrix: a pressed key pulls its row low in its column.
  always_comb begin
    logic [3:0] r;
    r = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!kp.o_col[c]) r = r & ~keys[c*4 +: 4];
    kp.i_row = r;
  end

  bit         m_held;
  logic [3:0] m_code;
  int         run, last, erun;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    m_held = 0;
    m_code = '0;
    run    = 0;
    last   = -1;
    erun   = 0;
  endtask

  // Press: DF consecutive frames with the same lone key while free.
  // Release: DF consecutive empty frames while held.
  task automatic model_frame(input logic [15:0] m,
                             output bit pv, output bit rv);
    int n, k;
    pv = 0;
    rv = 0;
    n  = $countones(m);
    k  = 0;
    for (int i = 0; i < 16; i++) if (m[i]) k = i;
    if (!m_held) begin
      if (n == 1) begin
        if (k == last) run++;
        else begin
          last = k;
          run  = 1;
        end
      end else begin
        run  = 0;
        last = -1;
      end
      if (run == DF) begin
        pv     = 1;
        m_held = 1;
        m_code = 4'(k);
        run    = 0;
        last   = -1;
        erun   = 0;
      end
    end else begin
      if (n == 0) erun++;
      else erun = 0;
      if (erun == DF) begin
        rv     = 1;
        m_held = 0;
        erun   = 0;
      end
    end
  endtask

  task automatic run_frame(input logic [15:0] m);
    bit         pv, rv;
    bit         oh;
    logic [3:0] oc, ec;
    oh   = m_held;
    oc   = m_code;
    keys = m;
    model_frame(m, pv, rv);
    for (int i = 1; i <= FR; i++) begin
      @(posedge clk);
      @(negedge clk);
      ec = 4'hF;
      ec[(i / SD) % 4] = 1'b0;
      chk("col", kp.o_col, ec);
      if (i < FR) begin
        chk("valid", kp.o_key_valid, 0);
        chk("release", kp.o_key_release, 0);
        chk("held", kp.o_key_held, oh);
        chk("code", kp.o_key_code, oc);
      end else begin
        chk("valid_fe", kp.o_key_valid, pv);
        chk("release_fe", kp.o_key_release, rv);
        chk("held_fe", kp.o_key_held, m_held);
        chk("code_fe", kp.o_key_code, m_code);
      end
    end
  endtask

  task automatic frames(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) run_frame(m);
  endtask

  task automatic do_reset(input int pre);
    repeat (pre) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_col", kp.o_col, 4'b1110);
    chk("rst_code", kp.o_key_code, 0);
    chk("rst_valid", kp.o_key_valid, 0);
    chk("rst_held", kp.o_key_held, 0);
    chk("rst_release", kp.o_key_release, 0);
    model_reset();
    keys = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [15:0] K6  = 16'h0040;
  localparam logic [15:0] K05 = 16'h0021;

  initial begin
    logic [15:0] m;
    int          a, b, sel, nf;
    model_reset();
    do_reset(1);
    frames('0, 10);
    frames(K6, 5);
    frames('0, 4);
    for (int i = 0; i < 6; i++) run_frame((i % 2 == 0) ? K6 : '0);
    frames(K6, 3);
    frames('0, 4);
    frames(K05, 8);
    frames('0, 2);
    frames(K6, 10);
    frames('0, 4);
    frames(K6, 2);
    do_reset(5);
    frames(K6, 3);
    frames('0, 1);
    do_reset(7);
    frames('0, 1);
    m = '0;
    for (int s = 0; s < 45; s++) begin
      sel = int'($urandom_range(0, 3));
      nf  = int'($urandom_range(1, 5));
      a   = int'($urandom_range(0, 15));
      b   = (a + int'($urandom_range(1, 15))) % 16;
      if (sel == 0) m = '0;
      else if (sel == 1) m = 16'h1 << a;
      else if (sel == 2) m = (16'h1 << a) | (16'h1 << b);
      frames(m, nf);
    end
    frames('0, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
